uart_tx: RTL and testbench

- Byte-serial UART transmitter; the outbound counterpart of the core's `io_rx` receive path.
- Accepts bytes from the CPU-side store path over a valid/ready handshake and buffers them in a small FIFO.
- Drives the `io_tx` pin as 8N1 frames, LSB first.
- Gives the core a console/debug output channel and a path to echo program-load data back to the host.

---
 rtl/uart_tx.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shift register.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1, 11 bit periods per frame).
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [7:0]                         tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               io_tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif
    logic               push, pop, baud_done, fifo_nonempty;

    // Ready comes only from the registered count, so a same-edge pop never frees a full FIFO early.
    assign tx_ready      = (count_q != FULL);
    assign push          = tx_valid && tx_ready;
    assign fifo_nonempty = (count_q != '0);
    assign baud_done     = (baud_q == BAUD_LAST);
    assign busy          = (state_q != IDLE) || fifo_nonempty;
    assign fifo_count    = count_q;
    assign io_tx         = tx_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop      = 1'b1;
                    shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d = ^mem_q[rd_ptr_q];
`endif
                    tx_d     = 1'b0;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so queued bytes go out with no idle gap.
                    if (fifo_nonempty) begin
                        pop      = 1'b1;
                        shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                        parity_d = ^mem_q[rd_ptr_q];
`endif
                        tx_d     = 1'b0;
                        state_d  = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of single frames plus hand-written back-to-back,
// FIFO-full and mid-frame reset sequences. Honours UART_TX_PARITY_EN for frame layout.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       io_tx;
    logic       busy;
    logic [2:0] fifo_count;

    int testsRun;
    int testsFailed;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .io_tx     (io_tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent line decoder: samples mid-bit on falling clock edges, aborts on reset.
    logic [7:0] monQ[$];
    logic       monActive;
    int         monCnt;
    logic [7:0] monShift;
    int         monFrameErr;

    initial begin
        monActive   = 1'b0;
        monCnt      = 0;
        monShift    = '0;
        monFrameErr = 0;
    end

    always @(negedge clk) begin
        if (reset) begin
            monActive <= 1'b0;
            monCnt    <= 0;
        end else if (!monActive) begin
            if (io_tx === 1'b0) begin
                monActive <= 1'b1;
                monCnt    <= 1;
            end
        end else begin
            monCnt <= monCnt + 1;
            if (monCnt % CPB == CPB / 2) begin
                if (monCnt / CPB >= 1 && monCnt / CPB <= 8) begin
                    monShift <= {io_tx, monShift[7:1]};
                end else if (monCnt / CPB == NB - 1) begin
                    monQ.push_back(monShift);
                    if (io_tx !== 1'b1) monFrameErr <= monFrameErr + 1;
                    monActive <= 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       expParity;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called right after the edge that launches the start bit; returns after the frame's last edge.
    task automatic expectFrame(input logic [7:0] b, input logic expPar, input string name);
        logic [10:0] bits;
        logic        exp;
        logic        got;
        logic        busyOk;
        bits   = {1'b1, expPar, b, 1'b0};
        busyOk = 1'b1;
        for (int bi = 0; bi < NB; bi++) begin
            exp = (bi == NB - 1) ? 1'b1 : bits[bi];
            got = exp;
            for (int c = 0; c < CPB; c++) begin
                if (io_tx !== exp) got = io_tx;
                if (busy !== 1'b1) busyOk = 1'b0;
                tick();
            end
            checkOutput($sformatf("%s bit%0d", name, bi), {31'd0, got}, {31'd0, exp});
        end
        checkOutput($sformatf("%s busy in frame", name), {31'd0, busyOk}, 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic expPar, input string name);
        int base;
        base = monQ.size();
        checkOutput($sformatf("%s ready", name), {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        checkOutput($sformatf("%s line at edge0", name), {31'd0, io_tx}, 32'd1);
        checkOutput($sformatf("%s count at edge0", name), {29'd0, fifo_count}, 32'd1);
        tick();
        expectFrame(b, expPar, name);
        checkOutput($sformatf("%s busy after frame", name), {31'd0, busy}, 32'd0);
        checkOutput($sformatf("%s decoded count", name), monQ.size() - base, 32'd1);
        if (monQ.size() > base)
            checkOutput($sformatf("%s decoded byte", name), {24'd0, monQ[base]}, {24'd0, b});
    endtask

    initial begin
        vec_t       vecs[7];
        logic [7:0] acc[$];
        int         base;
        int         cyc;
        int         readyEdge;
        logic       heldFull;
        int         n;

        testsRun    = 0;
        testsFailed = 0;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h81, 1'b0};
        vecs[4] = '{8'h07, 1'b1};
        vecs[5] = '{8'h03, 1'b0};
        vecs[6] = '{8'h80, 1'b1};

        #1;
        checkOutput("reset io_tx", {31'd0, io_tx}, 32'd1);
        checkOutput("reset tx_ready", {31'd0, tx_ready}, 32'd1);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset fifo_count", {29'd0, fifo_count}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].data, vecs[i].expParity, $sformatf("vec%0d", i));
            tick();
        end

        // Back-to-back: second start must follow the first stop with no gap.
        base     = monQ.size();
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_data  = 8'h3C;
        tick();
        tx_valid = 1'b0;
        checkOutput("b2b push+pop count", {29'd0, fifo_count}, 32'd1);
        expectFrame(8'hA5, 1'b0, "b2b first");
        expectFrame(8'h3C, 1'b0, "b2b second");
        checkOutput("b2b busy after", {31'd0, busy}, 32'd0);
        checkOutput("b2b decoded count", monQ.size() - base, 32'd2);
        if (monQ.size() >= base + 2) begin
            checkOutput("b2b byte0", {24'd0, monQ[base]}, 32'hA5);
            checkOutput("b2b byte1", {24'd0, monQ[base+1]}, 32'h3C);
        end
        tick();

        // FIFO full: offer 0x01..0x08 for 8 cycles, then hold 0x06 until it is taken.
        base = monQ.size();
        cyc  = 0;
        for (int i = 0; i < 8; i++) begin
            tx_data  = 8'(i + 1);
            tx_valid = 1'b1;
            if (tx_ready) acc.push_back(8'(i + 1));
            tick();
            cyc = i;
        end
        checkOutput("full accepted count", acc.size(), 32'd5);
        for (int k = 0; k < acc.size() && k < 5; k++)
            checkOutput($sformatf("full accepted%0d", k), {24'd0, acc[k]}, 32'(k + 1));
        checkOutput("full fifo_count", {29'd0, fifo_count}, 32'd4);
        checkOutput("full tx_ready", {31'd0, tx_ready}, 32'd0);
        tx_data   = 8'h06;
        readyEdge = -1;
        heldFull  = 1'b1;
        while (cyc < 200) begin
            if (tx_ready) begin
                readyEdge = cyc;
                break;
            end
            if (fifo_count !== 3'd4) heldFull = 1'b0;
            tick();
            cyc++;
        end
        checkOutput("full ready reassert edge", readyEdge, 32'(1 + FRAME));
        checkOutput("full count held at 4", {31'd0, heldFull}, 32'd1);
        tick();
        tx_valid = 1'b0;
        checkOutput("full 0x06 accepted", {29'd0, fifo_count}, 32'd4);
        n = 0;
        while (busy && n < 8 * FRAME) begin
            tick();
            n++;
        end
        checkOutput("full drain busy", {31'd0, busy}, 32'd0);
        checkOutput("full decoded count", monQ.size() - base, 32'd6);
        for (int k = 0; k < 6 && base + k < monQ.size(); k++)
            checkOutput($sformatf("full order%0d", k), {24'd0, monQ[base+k]}, 32'(k + 1));
        tick();

        // Reset during data bit 3 of 0xFF, then a clean 0x81 frame.
        base     = monQ.size();
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (4 * CPB + 2) tick();
        checkOutput("rst busy mid-frame", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst async io_tx", {31'd0, io_tx}, 32'd1);
        checkOutput("rst async fifo_count", {29'd0, fifo_count}, 32'd0);
        checkOutput("rst async busy", {31'd0, busy}, 32'd0);
        checkOutput("rst async tx_ready", {31'd0, tx_ready}, 32'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rst aborted frame not decoded", monQ.size() - base, 32'd0);
        applyStimulus(8'h81, 1'b0, "after reset");

        checkOutput("monitor stop-bit errors", monFrameErr, 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
